multibyte_add_seq: RTL

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

---
 rtl/multibyte_add_seq_pkg.sv | 11 +
 rtl/multibyte_add_seq_prefix_add8_cin.sv | 59 +++++
 rtl/multibyte_add_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/multibyte_add_seq_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder.
package multibyte_add_seq_pkg;
   localparam int BYTE_W     = 8;
   localparam int NBYTES_MIN = 2;
   localparam int NBYTES_MAX = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/multibyte_add_seq_prefix_add8_cin.sv
// 8-bit Kogge-Stone adder with carry-in, carry-out and signed overflow.
module prefix_add8_cin
   import multibyte_add_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] i_a,
   input  logic [BYTE_W-1:0] i_b,
   input  logic              i_cin,
   output logic [BYTE_W-1:0] o_sum,
   output logic              o_cout,
   output logic              o_ovf
);
   logic [BYTE_W-1:0] w_g0, w_p0;
   logic [BYTE_W-1:0] w_g1, w_p1;
   logic [BYTE_W-1:0] w_g2, w_p2;
   logic [BYTE_W-1:0] w_g3, w_p3;
   logic [BYTE_W:0]   w_c;

   assign w_g0 = i_a & i_b;
   assign w_p0 = i_a ^ i_b;

   for (genvar i = 0; i < BYTE_W; i++) begin : g_l1
      if (i >= 1) begin : g_op
         assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
         assign w_p1[i] = w_p0[i] & w_p0[i-1];
      end else begin : g_pass
         assign w_g1[i] = w_g0[i];
         assign w_p1[i] = w_p0[i];
      end
   end

   for (genvar i = 0; i < BYTE_W; i++) begin : g_l2
      if (i >= 2) begin : g_op
         assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
         assign w_p2[i] = w_p1[i] & w_p1[i-2];
      end else begin : g_pass
         assign w_g2[i] = w_g1[i];
         assign w_p2[i] = w_p1[i];
      end
   end

   for (genvar i = 0; i < BYTE_W; i++) begin : g_l3
      if (i >= 4) begin : g_op
         assign w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
         assign w_p3[i] = w_p2[i] & w_p2[i-4];
      end else begin : g_pass
         assign w_g3[i] = w_g2[i];
         assign w_p3[i] = w_p2[i];
      end
   end

   // Carry-in enters as a generate below bit 0, propagated by group P.
   assign w_c[0]        = i_cin;
   assign w_c[BYTE_W:1] = w_g3 | (w_p3 & {BYTE_W{i_cin}});

   assign o_sum  = w_p0 ^ w_c[BYTE_W-1:0];
   assign o_cout = w_c[BYTE_W];
   assign o_ovf  = (i_a[BYTE_W-1] == i_b[BYTE_W-1])
                 & (o_sum[BYTE_W-1] != i_a[BYTE_W-1]);
endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES-wide adder, LSB first, valid/ready on both sides.
module multibyte_add_seq
   import multibyte_add_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] a_byte,
   input  logic [BYTE_W-1:0] b_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] sum_byte,
   output logic              out_last,
   output logic              carry_out,
   output logic              ovf
);
   localparam int CNT_W = (NBYTES > 2) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

   if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
      $error("multibyte_add_seq: NBYTES must be 2..16");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_carry;
   logic              r_valid;
   logic [BYTE_W-1:0] r_sum;
   logic              r_last;
   logic              r_cout;
   logic              r_ovf;

   logic              w_xfer;
   logic              w_last;
   logic              w_cin;
   logic [BYTE_W-1:0] w_sum;
   logic              w_cout;
   logic              w_ovf;

   prefix_add8_cin u_add (
      .i_a    (a_byte),
      .i_b    (b_byte),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clock) begin
      if (!reset_n)
         r_state <= IDLE;
      else if (enable)
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (!clear && w_xfer) w_state_nxt = RUN;
         RUN:     if (clear || (w_xfer && w_last)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A new operation always starts without carry, whatever r_carry holds.
   always_comb begin
      in_ready = enable & ~clear & (~r_valid | out_ready);
      w_xfer   = in_valid & in_ready;
      w_last   = (r_cnt == LAST_IDX);
      w_cin    = (r_state == RUN) & r_carry;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_last  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (enable) begin
         if (clear) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
         end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_last  <= w_last;
            r_cout  <= w_last & w_cout;
            r_ovf   <= w_last & w_ovf;
            r_carry <= ~w_last & w_cout;
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_valid;
   assign sum_byte  = r_sum;
   assign out_last  = r_last;
   assign carry_out = r_cout;
   assign ovf       = r_ovf;
endmodule
